ddr_arbiter: RTL and testbench
==============================

# ddr_arbiter

Two-port arbiter sharing the single DDR3 (Avalon-MM style) master port between the ROM download writer (port 0) and the frame buffer / tile fetch reader (port 1). Sits inside `Main` in the `clock` domain, between the requesters and the top-level `io_ddr_*` pins. It grants one burst at a time, holds the grant until the burst completes, and steers `valid`/`waitReq` back to the owning port only.

## Interface
- `ADDR_W`, 32: byte address width.
- `DATA_W`, 64: data width; mask width is `DATA_W/8`.
- `clock`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high reset.
- `io_in_N_rd`, `io_in_N_wr`  in  1 each  port N read/write request, N = 0,1; held until `io_in_N_waitReq` is low.
- `io_in_N_addr`  in  ADDR_W  burst start address.
- `io_in_N_burstLength`  in  8  beats, 1..128; a value of 0 is treated as 1.
- `io_in_N_mask` / `io_in_N_din`  in  8 / 64  write byte enables and write data.
- `io_in_N_waitReq`  out  1  stall; high whenever port N is not granted.
- `io_in_N_valid`  out  1  read beat for port N.
- `io_in_N_dout`  out  64  read data; `io_ddr_dout` is broadcast to both ports.
- `io_ddr_rd`, `io_ddr_wr`, `io_ddr_addr`, `io_ddr_mask`, `io_ddr_din`, `io_ddr_burstLength`  out  DDR command side.
- `io_ddr_dout`, `io_ddr_waitReq`, `io_ddr_valid`  in  DDR response side.
- `io_busy`  out  1  high in any state except IDLE.

## Operation
- States: IDLE, WRITE, READ_CMD, READ_DATA.
- IDLE: all DDR outputs are 0 and both port `waitReq` are 1. The arbiter picks a requester (`rd|wr`), latches `grant`, latches `burstLength` (with 0 mapped to 1), and clears the beat counter.
  - Next state is WRITE if the winner asserts `wr`, else READ_CMD.
  - If a port asserts both `rd` and `wr`, `wr` wins.
- WRITE: the granted port's `wr/addr/mask/din/burstLength` pass combinationally to DDR. Port `waitReq` equals `io_ddr_waitReq`.
  - Each `wr & ~io_ddr_waitReq` counts one beat.
  - The last beat (count == len-1) returns the FSM to IDLE.
- READ_CMD: the granted port's `rd/addr/burstLength` pass through. On `rd & ~io_ddr_waitReq` the FSM moves to READ_DATA and `io_ddr_rd` drops.
- READ_DATA: DDR outputs are 0 and the port sees `waitReq` = 1.
  - Each `io_ddr_valid` pulses `io_in_grant_valid` and counts one beat.
  - The last beat returns the FSM to IDLE.
- `io_ddr_valid` in IDLE, WRITE or READ_CMD is dropped: no port sees it, and it does not count.
- Addresses and data are never modified. The 8-bit beat counter never wraps because length is ≤128.
- Reset mid-burst: the FSM goes to IDLE and all outputs return to reset values. A partially transferred burst is abandoned; the requester must reissue it.

## Timing
- Reset values:
  - `io_ddr_rd`, `io_ddr_wr`, `io_ddr_addr`, `io_ddr_mask`, `io_ddr_din`, `io_ddr_burstLength` = 0.
  - `io_in_N_valid` = 0, `io_in_N_waitReq` = 1, `io_busy` = 0.
  - Round-robin pointer `last` = 1.
- Grant latency:
  - A request first seen in IDLE at cycle t appears on `io_ddr_*` at t+1.
  - The earliest DDR acceptance is at t+1.
- Burst end: the last write beat or last read `valid` occurs at cycle n. The FSM is in IDLE at n+1, and a pending request is on DDR at n+2.
- Read data has zero added latency: `io_in_N_valid`/`dout` are combinational from `io_ddr_valid`/`io_ddr_dout`.
- Only one burst is ever outstanding.

## Configuration
- `DDR_ARBITER_ROUND_ROBIN_EN` defined: when both ports request in IDLE, the port ≠ `last` wins, and `last` updates on every grant. Port 0 therefore wins first after reset.
- Undefined: fixed priority, port 0 always wins ties, and no `last` register is built.

## Test plan
- Single write burst: port 0 `wr`, len 4, addr 0x100, `io_ddr_waitReq` high on beat 2 for 2 cycles.
  - Expect exactly 4 DDR write beats with data in order.
  - Expect port 0 `waitReq` mirroring DDR.
  - Expect IDLE one cycle after the 4th beat.
- Read burst: port 1 `rd`, len 8, DDR returns 8 `valid` with gaps.
  - Expect `io_ddr_rd` high for exactly one accepted cycle.
  - Expect port 1 sees 8 `valid`, port 0 sees 0.
- Both ports request in the same IDLE cycle, three times back-to-back.
  - Round-robin: expected grant sequence 0,1,0.
  - Fixed priority: expected grant sequence 0,0,0 while port 0 keeps requesting.
- `burstLength` = 0 on a read: expect the burst is treated as 1 beat and IDLE follows after 1 `valid`.
- Assert `reset` after read beat 3 of 8: expect `io_busy` = 0, port `waitReq` = 1, and late `io_ddr_valid` pulses ignored.
- Spurious `io_ddr_valid` while in IDLE: expect no port `valid` and no state change.

Source files
------------

// File: rtl/ddr_arbiter.sv
// ddr_arbiter: grants the shared DDR3 master port to one of two requesters, one burst at a time.
// Define DDR_ARBITER_ROUND_ROBIN_EN for round-robin tie breaking; default is fixed port-0 priority.
module ddr_arbiter #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 64
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                io_in_0_rd,
   input  logic                io_in_0_wr,
   input  logic [ADDR_W-1:0]   io_in_0_addr,
   input  logic [7:0]          io_in_0_burstLength,
   input  logic [DATA_W/8-1:0] io_in_0_mask,
   input  logic [DATA_W-1:0]   io_in_0_din,
   output logic                io_in_0_waitReq,
   output logic                io_in_0_valid,
   output logic [DATA_W-1:0]   io_in_0_dout,
   input  logic                io_in_1_rd,
   input  logic                io_in_1_wr,
   input  logic [ADDR_W-1:0]   io_in_1_addr,
   input  logic [7:0]          io_in_1_burstLength,
   input  logic [DATA_W/8-1:0] io_in_1_mask,
   input  logic [DATA_W-1:0]   io_in_1_din,
   output logic                io_in_1_waitReq,
   output logic                io_in_1_valid,
   output logic [DATA_W-1:0]   io_in_1_dout,
   output logic                io_ddr_rd,
   output logic                io_ddr_wr,
   output logic [ADDR_W-1:0]   io_ddr_addr,
   output logic [DATA_W/8-1:0] io_ddr_mask,
   output logic [DATA_W-1:0]   io_ddr_din,
   output logic [7:0]          io_ddr_burstLength,
   input  logic [DATA_W-1:0]   io_ddr_dout,
   input  logic                io_ddr_waitReq,
   input  logic                io_ddr_valid,
   output logic                io_busy
);

   localparam logic [1:0] S_IDLE      = 2'd0;
   localparam logic [1:0] S_WRITE     = 2'd1;
   localparam logic [1:0] S_READ_CMD  = 2'd2;
   localparam logic [1:0] S_READ_DATA = 2'd3;

   logic [1:0]          state_q, state_d;
   logic                grant_q, grant_d;
   logic [7:0]          len_q, len_d;
   logic [7:0]          cnt_q, cnt_d;

   logic                req_0, req_1, winner;
   logic                w_wr;
   logic [7:0]          w_bl, w_len;
   logic                g_rd, g_wr;
   logic [ADDR_W-1:0]   g_addr;
   logic [7:0]          g_bl, g_len;
   logic [DATA_W/8-1:0] g_mask;
   logic [DATA_W-1:0]   g_din;
   logic                g_wq, g_vld;

   assign req_0 = io_in_0_rd | io_in_0_wr;
   assign req_1 = io_in_1_rd | io_in_1_wr;

`ifdef DDR_ARBITER_ROUND_ROBIN_EN
   logic last_q, last_d;

   // On a tie the port that did not win last time goes first.
   always_comb begin
      winner = req_1 & (~req_0 | ~last_q);
      last_d = last_q;
      if (state_q == S_IDLE && (req_0 | req_1)) begin
         last_d = winner;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         last_q <= 1'b1;
      end else begin
         last_q <= last_d;
      end
   end
`else
   always_comb begin
      winner = ~req_0 & req_1;
   end
`endif

   assign w_wr  = winner ? io_in_1_wr : io_in_0_wr;
   assign w_bl  = winner ? io_in_1_burstLength : io_in_0_burstLength;
   assign w_len = (w_bl == 8'd0) ? 8'd1 : w_bl;

   assign g_rd   = grant_q ? io_in_1_rd   : io_in_0_rd;
   assign g_wr   = grant_q ? io_in_1_wr   : io_in_0_wr;
   assign g_addr = grant_q ? io_in_1_addr : io_in_0_addr;
   assign g_bl   = grant_q ? io_in_1_burstLength : io_in_0_burstLength;
   assign g_mask = grant_q ? io_in_1_mask : io_in_0_mask;
   assign g_din  = grant_q ? io_in_1_din  : io_in_0_din;
   assign g_len  = (g_bl == 8'd0) ? 8'd1 : g_bl;

   always_comb begin
      state_d            = state_q;
      grant_d            = grant_q;
      len_d              = len_q;
      cnt_d              = cnt_q;
      io_ddr_rd          = 1'b0;
      io_ddr_wr          = 1'b0;
      io_ddr_addr        = '0;
      io_ddr_mask        = '0;
      io_ddr_din         = '0;
      io_ddr_burstLength = '0;
      g_wq               = 1'b1;
      g_vld              = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (req_0 | req_1) begin
               grant_d = winner;
               len_d   = w_len;
               cnt_d   = 8'd0;
               state_d = w_wr ? S_WRITE : S_READ_CMD;
            end
         end
         S_WRITE: begin
            io_ddr_wr          = g_wr;
            io_ddr_addr        = g_addr;
            io_ddr_mask        = g_mask;
            io_ddr_din         = g_din;
            io_ddr_burstLength = g_len;
            g_wq               = io_ddr_waitReq;
            if (g_wr && !io_ddr_waitReq) begin
               cnt_d = cnt_q + 8'd1;
               if (cnt_q == len_q - 8'd1) begin
                  state_d = S_IDLE;
               end
            end
         end
         S_READ_CMD: begin
            io_ddr_rd          = g_rd;
            io_ddr_addr        = g_addr;
            io_ddr_burstLength = g_len;
            g_wq               = io_ddr_waitReq;
            if (g_rd && !io_ddr_waitReq) begin
               state_d = S_READ_DATA;
            end
         end
         default: begin
            // Read data phase: the command is gone, only response beats are counted.
            g_vld = io_ddr_valid;
            if (io_ddr_valid) begin
               cnt_d = cnt_q + 8'd1;
               if (cnt_q == len_q - 8'd1) begin
                  state_d = S_IDLE;
               end
            end
         end
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         grant_q <= 1'b0;
         len_q   <= 8'd1;
         cnt_q   <= 8'd0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         len_q   <= len_d;
         cnt_q   <= cnt_d;
      end
   end

   assign io_in_0_waitReq = grant_q ? 1'b1 : g_wq;
   assign io_in_1_waitReq = grant_q ? g_wq : 1'b1;
   assign io_in_0_valid   = ~grant_q & g_vld;
   assign io_in_1_valid   = grant_q & g_vld;
   assign io_in_0_dout    = io_ddr_dout;
   assign io_in_1_dout    = io_ddr_dout;
   assign io_busy         = (state_q != S_IDLE);

endmodule

// File: tb/tb_ddr_arbiter.sv
// Bench for ddr_arbiter: vector table, scripted corner cases, and a randomized run vs a burst-level model.
`timescale 1ns/1ps
module tb_ddr_arbiter;

`ifdef DDR_ARBITER_ROUND_ROBIN_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   logic        clock = 1'b0;
   logic        reset;
   logic        io_in_0_rd, io_in_0_wr, io_in_1_rd, io_in_1_wr;
   logic [31:0] io_in_0_addr, io_in_1_addr;
   logic [7:0]  io_in_0_burstLength, io_in_1_burstLength;
   logic [7:0]  io_in_0_mask, io_in_1_mask;
   logic [63:0] io_in_0_din, io_in_1_din;
   logic        io_in_0_waitReq, io_in_0_valid, io_in_1_waitReq, io_in_1_valid;
   logic [63:0] io_in_0_dout, io_in_1_dout;
   logic        io_ddr_rd, io_ddr_wr;
   logic [31:0] io_ddr_addr;
   logic [7:0]  io_ddr_mask, io_ddr_burstLength;
   logic [63:0] io_ddr_din, io_ddr_dout;
   logic        io_ddr_waitReq, io_ddr_valid;
   logic        io_busy;

   int n_checks = 0;
   int n_fail   = 0;

   ddr_arbiter dut (
      .clock(clock), .reset(reset),
      .io_in_0_rd(io_in_0_rd), .io_in_0_wr(io_in_0_wr), .io_in_0_addr(io_in_0_addr),
      .io_in_0_burstLength(io_in_0_burstLength), .io_in_0_mask(io_in_0_mask), .io_in_0_din(io_in_0_din),
      .io_in_0_waitReq(io_in_0_waitReq), .io_in_0_valid(io_in_0_valid), .io_in_0_dout(io_in_0_dout),
      .io_in_1_rd(io_in_1_rd), .io_in_1_wr(io_in_1_wr), .io_in_1_addr(io_in_1_addr),
      .io_in_1_burstLength(io_in_1_burstLength), .io_in_1_mask(io_in_1_mask), .io_in_1_din(io_in_1_din),
      .io_in_1_waitReq(io_in_1_waitReq), .io_in_1_valid(io_in_1_valid), .io_in_1_dout(io_in_1_dout),
      .io_ddr_rd(io_ddr_rd), .io_ddr_wr(io_ddr_wr), .io_ddr_addr(io_ddr_addr),
      .io_ddr_mask(io_ddr_mask), .io_ddr_din(io_ddr_din), .io_ddr_burstLength(io_ddr_burstLength),
      .io_ddr_dout(io_ddr_dout), .io_ddr_waitReq(io_ddr_waitReq), .io_ddr_valid(io_ddr_valid),
      .io_busy(io_busy)
   );

   always #5 clock = ~clock;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // {busy, waitReq0, waitReq1, valid0, valid1, ddr_rd, ddr_wr}
   function automatic logic [6:0] ctrl();
      return {io_busy, io_in_0_waitReq, io_in_1_waitReq, io_in_0_valid, io_in_1_valid, io_ddr_rd, io_ddr_wr};
   endfunction

   task automatic cyc();
      @(posedge clock);
      #1;
   endtask

   task automatic idle_inputs();
      io_in_0_rd = 0; io_in_0_wr = 0; io_in_1_rd = 0; io_in_1_wr = 0;
      io_in_0_addr = 32'h100; io_in_1_addr = 32'h200;
      io_in_0_burstLength = 8'd1; io_in_1_burstLength = 8'd1;
      io_in_0_mask = 8'hFF; io_in_1_mask = 8'hFF;
      io_in_0_din = '0; io_in_1_din = '0;
      io_ddr_waitReq = 0; io_ddr_valid = 0; io_ddr_dout = '0;
   endtask

   task automatic do_reset();
      idle_inputs();
      reset = 1;
      cyc();
      cyc();
      reset = 0;
   endtask

   typedef struct {
      logic        wr0;
      logic [63:0] din;
      logic        wq;
      logic        vld;
      logic [6:0]  e_ctrl;
      logic [63:0] e_din;
   } wvec_t;

   wvec_t wt[8];

   // burst-level reference state for the random run
   int          m_own, m_ph, m_left, o, w;
   bit          m_last;
   bit          act[2], isw[2], cmdd[2], xr[2], pw[2], pr[2];
   int          blen[2];
   logic [31:0] a[2];
   logic [63:0] d[2];
   logic [7:0]  mk[2];
   bit          e_rd, e_wr, e_busy;
   bit [1:0]    e_wq, e_v;
   int          nb, rd_acc, v0c, v1c, ng;
   int          gseq[3];
   logic [63:0] dat;

   initial begin
      reset = 1;
      idle_inputs();
      cyc();
      cyc();
      @(negedge clock);
      chk("reset_ctrl", 64'(ctrl()), 64'(7'b0110000));
      chk("reset_addr", 64'(io_ddr_addr), 64'(0));
      chk("reset_din", io_ddr_din, 64'(0));
      chk("reset_mask_bl", 64'({io_ddr_mask, io_ddr_burstLength}), 64'(0));
      cyc();
      reset = 0;

      // ---- single write burst, DDR stalls on beat 2 for two cycles ----
      wt[0] = '{1, 64'hA000_0000_0000_0000, 0, 1, 7'b0110000, 64'h0};
      wt[1] = '{1, 64'hA000_0000_0000_0000, 0, 0, 7'b1010001, 64'hA000_0000_0000_0000};
      wt[2] = '{1, 64'hA111_1111_1111_1111, 0, 0, 7'b1010001, 64'hA111_1111_1111_1111};
      wt[3] = '{1, 64'hA222_2222_2222_2222, 1, 1, 7'b1110001, 64'hA222_2222_2222_2222};
      wt[4] = '{1, 64'hA222_2222_2222_2222, 1, 0, 7'b1110001, 64'hA222_2222_2222_2222};
      wt[5] = '{1, 64'hA222_2222_2222_2222, 0, 0, 7'b1010001, 64'hA222_2222_2222_2222};
      wt[6] = '{1, 64'hA333_3333_3333_3333, 0, 0, 7'b1010001, 64'hA333_3333_3333_3333};
      wt[7] = '{0, 64'h0, 0, 0, 7'b0110000, 64'h0};
      io_in_0_burstLength = 8'd4;
      nb = 0;
      for (int i = 0; i < 8; i++) begin
         io_in_0_wr = wt[i].wr0;
         io_in_0_din = wt[i].din;
         io_ddr_waitReq = wt[i].wq;
         io_ddr_valid = wt[i].vld;
         io_ddr_dout = {$urandom, $urandom};
         @(negedge clock);
         chk($sformatf("wr_ctrl[%0d]", i), 64'(ctrl()), 64'(wt[i].e_ctrl));
         chk($sformatf("wr_din[%0d]", i), io_ddr_din, wt[i].e_din);
         chk($sformatf("wr_addr[%0d]", i), 64'(io_ddr_addr), wt[i].e_ctrl[0] ? 64'h100 : 64'h0);
         chk($sformatf("wr_bl[%0d]", i), 64'(io_ddr_burstLength), wt[i].e_ctrl[0] ? 64'd4 : 64'd0);
         if (io_ddr_wr && !io_ddr_waitReq) nb++;
         cyc();
      end
      chk("wr_beats", 64'(nb), 64'(4));
      idle_inputs();

      // ---- read burst on port 1, len 8, data with gaps ----
      io_in_1_rd = 1; io_in_1_addr = 32'h2000; io_in_1_burstLength = 8'd8;
      rd_acc = 0; v0c = 0; v1c = 0;
      for (int k = 0; k < 60 && v1c < 8; k++) begin
         io_ddr_waitReq = (k < 2);
         io_ddr_valid = (k % 2 == 1);
         io_ddr_dout = {$urandom, $urandom};
         @(negedge clock);
         if (io_ddr_rd && !io_ddr_waitReq) rd_acc++;
         if (io_in_0_valid) v0c++;
         if (io_in_1_valid) begin
            v1c++;
            chk("rd_dout", io_in_1_dout, io_ddr_dout);
         end
         if (!io_in_1_waitReq) begin
            cyc();
            io_in_1_rd = 0;
         end else begin
            cyc();
         end
      end
      chk("rd_beats_p1", 64'(v1c), 64'(8));
      chk("rd_beats_p0", 64'(v0c), 64'(0));
      chk("rd_cmd_accepts", 64'(rd_acc), 64'(1));
      io_ddr_valid = 0;
      @(negedge clock);
      chk("rd_end_idle", 64'(ctrl()), 64'(7'b0110000));
      cyc();

      // ---- simultaneous requests, three grants in a row ----
      do_reset();
      io_in_0_wr = 1; io_in_1_wr = 1;
      ng = 0;
      for (int k = 0; k < 20 && ng < 3; k++) begin
         @(negedge clock);
         if (io_ddr_wr && !io_ddr_waitReq) begin
            gseq[ng] = (io_ddr_addr == 32'h200) ? 1 : 0;
            ng++;
         end
         cyc();
      end
      chk("arb_grants", 64'(ng), 64'(3));
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("arb_seq[%0d]", i), 64'(gseq[i]), RR ? 64'(i % 2) : 64'(0));
      end
      idle_inputs();
      cyc();

      // ---- burstLength 0 read counts as one beat ----
      io_in_0_rd = 1; io_in_0_addr = 32'h300; io_in_0_burstLength = 8'd0;
      @(negedge clock);
      chk("bl0_idle", 64'(ctrl()), 64'(7'b0110000));
      cyc();
      @(negedge clock);
      chk("bl0_cmd", 64'(ctrl()), 64'(7'b1010010));
      cyc();
      io_in_0_rd = 0; io_ddr_valid = 1; dat = 64'hDEAD_BEEF_0123_4567; io_ddr_dout = dat;
      @(negedge clock);
      chk("bl0_valid", 64'(ctrl()), 64'(7'b1111000));
      chk("bl0_dout", io_in_0_dout, dat);
      cyc();
      @(negedge clock);
      chk("bl0_done", 64'(ctrl()), 64'(7'b0110000));
      cyc();
      idle_inputs();

      // ---- reset after read beat 3 of 8 ----
      io_in_1_rd = 1; io_in_1_addr = 32'h400; io_in_1_burstLength = 8'd8;
      cyc();
      cyc();
      io_in_1_rd = 0; io_ddr_valid = 1;
      v1c = 0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clock);
         if (io_in_1_valid) v1c++;
         cyc();
      end
      chk("rst_pre_beats", 64'(v1c), 64'(3));
      reset = 1;
      @(negedge clock);
      chk("rst_mid_ctrl", 64'(ctrl()), 64'(7'b0110000));
      cyc();
      reset = 0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clock);
         chk($sformatf("rst_late_valid[%0d]", k), 64'(ctrl()), 64'(7'b0110000));
         cyc();
      end
      idle_inputs();

      // ---- randomized traffic against the burst-level model ----
      do_reset();
      m_own = -1; m_ph = 0; m_left = 0; m_last = 1'b1;
      for (int p = 0; p < 2; p++) begin
         act[p] = 0; isw[p] = 0; cmdd[p] = 0; xr[p] = 0; blen[p] = 1;
         a[p] = '0; d[p] = '0; mk[p] = '0;
      end
      for (int cy = 0; cy < 3000; cy++) begin
         for (int p = 0; p < 2; p++) begin
            if (!act[p] && $urandom_range(0, 3) == 0) begin
               act[p] = 1; isw[p] = 1'($urandom_range(0, 1)); cmdd[p] = 0;
               xr[p] = 1'($urandom_range(0, 1)); blen[p] = int'($urandom_range(0, 6));
               a[p] = $urandom; d[p] = {$urandom, $urandom}; mk[p] = 8'($urandom);
            end
            pw[p] = act[p] & isw[p];
            pr[p] = act[p] & (isw[p] ? xr[p] : ~cmdd[p]);
         end
         io_in_0_wr = pw[0]; io_in_0_rd = pr[0]; io_in_0_addr = a[0];
         io_in_0_burstLength = 8'(blen[0]); io_in_0_din = d[0]; io_in_0_mask = mk[0];
         io_in_1_wr = pw[1]; io_in_1_rd = pr[1]; io_in_1_addr = a[1];
         io_in_1_burstLength = 8'(blen[1]); io_in_1_din = d[1]; io_in_1_mask = mk[1];
         io_ddr_waitReq = ($urandom_range(0, 3) == 0);
         io_ddr_valid = 1'($urandom_range(0, 1));
         io_ddr_dout = {$urandom, $urandom};
         @(negedge clock);

         e_busy = (m_own >= 0); e_wq = 2'b11; e_v = 2'b00; e_rd = 0; e_wr = 0;
         o = (m_own >= 0) ? m_own : 0;
         if (m_own >= 0) begin
            if (m_ph == 0) begin e_wr = pw[o]; e_wq[o] = io_ddr_waitReq; end
            else if (m_ph == 1) begin e_rd = pr[o]; e_wq[o] = io_ddr_waitReq; end
            else e_v[o] = io_ddr_valid;
         end
         chk("rnd_ctrl", 64'(ctrl()), 64'({e_busy, e_wq[0], e_wq[1], e_v[0], e_v[1], e_rd, e_wr}));
         if (e_wr || e_rd) begin
            chk("rnd_addr", 64'(io_ddr_addr), 64'(a[o]));
            chk("rnd_bl", 64'(io_ddr_burstLength), 64'((blen[o] == 0) ? 1 : blen[o]));
         end
         if (e_wr) chk("rnd_din_mask", {io_ddr_din[55:0], io_ddr_mask}, {d[o][55:0], mk[o]});
         if (e_v != 2'b00) chk("rnd_dout", (o == 1) ? io_in_1_dout : io_in_0_dout, io_ddr_dout);

         if (m_own < 0) begin
            if (pw[0] | pr[0] | pw[1] | pr[1]) begin
               if ((pw[0] | pr[0]) && (pw[1] | pr[1])) w = RR ? (m_last ? 0 : 1) : 0;
               else w = (pw[0] | pr[0]) ? 0 : 1;
               m_own = w; m_last = (w == 1);
               m_ph = pw[w] ? 0 : 1;
               m_left = (blen[w] == 0) ? 1 : blen[w];
            end
         end else if (m_ph == 0) begin
            if (pw[o] && !io_ddr_waitReq) begin
               d[o] = {$urandom, $urandom}; mk[o] = 8'($urandom);
               m_left--;
               if (m_left == 0) begin m_own = -1; act[o] = 0; end
            end
         end else if (m_ph == 1) begin
            if (pr[o] && !io_ddr_waitReq) begin m_ph = 2; cmdd[o] = 1; end
         end else if (io_ddr_valid) begin
            m_left--;
            if (m_left == 0) begin m_own = -1; act[o] = 0; end
         end
         cyc();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
